memory_wait_controller: RTL and testbench

Controller half of the memory-wait pipeline stage. It decodes the instruction held in that stage and, for single data transfers (LDR/STR), sequences one variable-latency data-memory access. It holds the earlier stages with `sel_stall` until the memory acknowledges, then releases them and presents load data for one cycle. A bounded wait counter converts a memory that never answers into a sticky fault that halts the pipeline.

---
 rtl/memory_wait_controller.sv | 167 ++++++++++++++++
 tb/tb_memory_wait_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_wait_controller.sv
// memory_wait_controller
//   Controller half of the memory-wait pipeline stage. Decodes the instruction
//   held in the stage and, for LDR/STR, sequences one variable-latency data
//   memory access. Earlier stages are held with sel_stall until mem_ack, then
//   released for one DONE cycle in which load data is presented. A bounded
//   wait counter turns a memory that never answers into a sticky fault.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous reset, ACTIVE HIGH (legacy name kept)
//   instr_in     : instruction in the memory-wait stage
//   instr_valid  : stage holds a real instruction
//   branch_flush : squash request for the instruction in this stage
//   mem_ack      : data memory completion strobe
//   mem_rdata    : read data, valid with mem_ack
//   mem_req      : registered access request
//   mem_we       : registered write enable (1 = store)
//   sel_stall    : hold earlier pipeline stages
//   status_rdy   : idle and not starting an access
//   load_data    : last captured read data
//   load_valid   : one-cycle load result strobe
//   mem_fault    : sticky timeout fault
module memory_wait_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        branch_flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        sel_stall,
  output logic        status_rdy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_FAULT
  } state_t;

  // Counter value seen during the TIMEOUT-th ACCESS cycle (counter starts at 0).
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        mem_fault_q, mem_fault_d;

  logic is_mem;
  logic start;
  logic unused_instr_bits;

  assign unused_instr_bits = ^{instr_in[31:28], instr_in[25:21], instr_in[19:0]};

  always_comb begin
    is_mem = instr_valid & (instr_in[27:26] == 2'b01);
    start  = is_mem & ~branch_flush & (state_q == S_IDLE);

    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    mem_we_d    = mem_we_q;
    load_data_d = load_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCESS;
          cnt_d     = '0;
          is_load_d = instr_in[20];
          mem_we_d  = ~instr_in[20];
        end
      end
      S_ACCESS: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // Ack wins over timeout when both land in the same cycle.
        if (mem_ack) begin
          state_d = S_DONE;
          if (is_load_q) load_data_d = mem_rdata;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    mem_req_d    = (state_d == S_ACCESS);
    load_valid_d = (state_d == S_DONE) & is_load_q;
    mem_fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mem_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      mem_fault_q  <= mem_fault_d;
    end
  end

  // Stall/ready are combinational so the stage is held in the detect cycle;
  // while reset is held they are forced to their idle values.
  always_comb begin
    sel_stall  = 1'b0;
    status_rdy = 1'b1;
    if (!rst_n) begin
      unique case (state_q)
        S_IDLE: begin
          sel_stall  = start;
          status_rdy = ~start;
        end
        S_ACCESS: begin
          sel_stall  = 1'b1;
          status_rdy = 1'b0;
        end
        S_DONE: begin
          sel_stall  = 1'b0;
          status_rdy = 1'b0;
        end
        S_FAULT: begin
          sel_stall  = 1'b1;
          status_rdy = 1'b0;
        end
        default: begin
          sel_stall  = 1'b0;
          status_rdy = 1'b1;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_memory_wait_controller.sv
// Bench for memory_wait_controller: three instances (TIMEOUT 2, 4, 16) share
// one stimulus stream. Each transaction's expected stall length, request
// length, load strobe count, load data and fault outcome are computed from
// the access latency and the instance timeout.
module tb_memory_wait_controller;

  localparam int NI = 3;
  localparam int TO [NI] = '{2, 4, 16};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        branch_flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        mem_req    [NI];
  logic        mem_we     [NI];
  logic        sel_stall  [NI];
  logic        status_rdy [NI];
  logic [31:0] load_data  [NI];
  logic        load_valid [NI];
  logic        mem_fault  [NI];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_ld [NI];
  logic        exp_we [NI];

  always #5 clk = ~clk;

  memory_wait_controller #(.TIMEOUT(2)) u_dut_t2 (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .branch_flush(branch_flush), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .sel_stall(sel_stall[0]),
    .status_rdy(status_rdy[0]), .load_data(load_data[0]),
    .load_valid(load_valid[0]), .mem_fault(mem_fault[0]));

  memory_wait_controller #(.TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .branch_flush(branch_flush), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .sel_stall(sel_stall[1]),
    .status_rdy(status_rdy[1]), .load_data(load_data[1]),
    .load_valid(load_valid[1]), .mem_fault(mem_fault[1]));

  memory_wait_controller #(.TIMEOUT(16)) u_dut_t16 (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .branch_flush(branch_flush), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req[2]), .mem_we(mem_we[2]), .sel_stall(sel_stall[2]),
    .status_rdy(status_rdy[2]), .load_data(load_data[2]),
    .load_valid(load_valid[2]), .mem_fault(mem_fault[2]));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s [TIMEOUT=%0d] observed=%h expected=%h", tag, TO[inst], obs, exp);
    end
  endtask

  // Reset with a live LDR presented: outputs must still show idle values.
  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b1;
    instr_in     = 32'hE5901000;
    instr_valid  = 1'b1;
    branch_flush = 1'b0;
    mem_ack      = 1'b0;
    @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("rst_mem_req",    i, 32'(mem_req[i]),    32'd0);
      chk("rst_mem_we",     i, 32'(mem_we[i]),     32'd0);
      chk("rst_load_data",  i, load_data[i],       32'd0);
      chk("rst_load_valid", i, 32'(load_valid[i]), 32'd0);
      chk("rst_mem_fault",  i, 32'(mem_fault[i]),  32'd0);
      chk("rst_sel_stall",  i, 32'(sel_stall[i]),  32'd0);
      chk("rst_status_rdy", i, 32'(status_rdy[i]), 32'd1);
      exp_ld[i] = '0;
      exp_we[i] = 1'b0;
    end
    @(negedge clk);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
  endtask

  // lat = ACCESS cycle carrying mem_ack (1-based); 0 = memory never answers.
  task automatic run_txn(input logic [31:0] instr, input logic valid,
                         input logic flush, input int lat,
                         input logic [31:0] rdata, input string tag);
    int  window;
    int  stall_n [NI];
    int  req_n   [NI];
    int  lv_n    [NI];
    bit  issue, ld, flt, any_fault;
    int  e_stall, e_req, e_lv;

    issue  = valid && (instr[27:26] == 2'b01) && !flush;
    ld     = instr[20];
    window = (lat == 0) ? 40 : lat + 3;
    for (int i = 0; i < NI; i++) begin
      stall_n[i] = 0; req_n[i] = 0; lv_n[i] = 0;
    end

    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      if (c == 0) begin
        instr_in     = instr;
        instr_valid  = valid;
        branch_flush = flush;
      end else if (issue) begin
        branch_flush = 1'($urandom_range(0, 1));
        if (lat != 0 && c > lat) instr_valid = 1'b0;
      end
      if (issue) mem_ack = (lat != 0 && c == lat);
      else       mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = (issue && c == lat) ? rdata : $urandom;
      #2;
      for (int i = 0; i < NI; i++) begin
        stall_n[i] += int'(sel_stall[i]);
        req_n[i]   += int'(mem_req[i]);
        lv_n[i]    += int'(load_valid[i]);
      end
    end
    mem_ack = 1'b0;

    any_fault = 0;
    for (int i = 0; i < NI; i++) begin
      flt = issue && (lat == 0 || lat > TO[i]);
      if (!issue) begin
        e_stall = 0; e_req = 0; e_lv = 0;
      end else if (flt) begin
        e_stall = window; e_req = TO[i]; e_lv = 0;
      end else begin
        e_stall = lat + 1; e_req = lat; e_lv = ld ? 1 : 0;
        if (ld) exp_ld[i] = rdata;
      end
      if (issue) exp_we[i] = !ld;
      chk({tag, "_stall_cycles"}, i, 32'(stall_n[i]), 32'(e_stall));
      chk({tag, "_req_cycles"},   i, 32'(req_n[i]),   32'(e_req));
      chk({tag, "_load_valid_n"}, i, 32'(lv_n[i]),    32'(e_lv));
      chk({tag, "_load_data"},    i, load_data[i],    exp_ld[i]);
      chk({tag, "_mem_we"},       i, 32'(mem_we[i]),  32'(exp_we[i]));
      chk({tag, "_mem_fault"},    i, 32'(mem_fault[i]), 32'(flt));
      chk({tag, "_status_rdy"},   i, 32'(status_rdy[i]), 32'(!flt));
      chk({tag, "_end_stall"},    i, 32'(sel_stall[i]), 32'(flt));
      if (flt) any_fault = 1;
    end
    if (any_fault) do_reset();
  endtask

  initial begin
    logic [31:0] r_instr;
    logic        r_valid, r_flush;
    int          r_lat, kind;

    for (int i = 0; i < NI; i++) begin
      exp_ld[i] = '0;
      exp_we[i] = 1'b0;
    end
    do_reset();

    run_txn(32'hE5801000, 1'b1, 1'b0, 1,  32'h12345678, "str_ack1");
    run_txn(32'hE5901000, 1'b1, 1'b0, 3,  32'hDEADBEEF, "ldr_ack3");
    run_txn(32'hE5801000, 1'b1, 1'b0, 2,  32'h0BADF00D, "str_keeps_ld");
    run_txn(32'hE5901000, 1'b1, 1'b0, 0,  32'h0,        "ldr_noack");
    run_txn(32'hE5901000, 1'b1, 1'b0, 2,  32'hA5A5A5A5, "ack_at_to2");
    run_txn(32'hE5901000, 1'b1, 1'b0, 4,  32'h5A5A5A5A, "ack_at_to4");
    run_txn(32'hE5901000, 1'b1, 1'b0, 16, 32'hCAFEF00D, "ack_at_to16");
    run_txn(32'hE5901000, 1'b1, 1'b0, 17, 32'h11112222, "ack_past_to16");
    run_txn(32'hE5901000, 1'b1, 1'b1, 1,  32'h33334444, "flush_idle");
    run_txn(32'hE0812003, 1'b1, 1'b0, 1,  32'h55556666, "non_mem");
    run_txn(32'hE5901000, 1'b0, 1'b0, 1,  32'h77778888, "bubble");

    // Reset arriving mid-access must drop the request at that edge.
    @(negedge clk);
    instr_in    = 32'hE5901000;
    instr_valid = 1'b1;
    mem_ack     = 1'b0;
    @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) chk("mid_access_req", i, 32'(mem_req[i]), 32'd1);
    do_reset();

    for (int n = 0; n < 30; n++) begin
      r_instr = $urandom;
      kind    = int'($urandom_range(0, 3));
      r_valid = 1'b1;
      if (kind <= 1)      r_instr[27:26] = 2'b01;
      else if (kind == 2) r_instr[27:26] = 2'b00;
      else begin
        r_instr[27:26] = 2'b01;
        r_valid        = 1'b0;
      end
      r_flush = ($urandom_range(0, 4) == 0);
      r_lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 18));
      run_txn(r_instr, r_valid, r_flush, r_lat, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
